game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer.sv | 158 +++++++++++++++
 tb/tb_game_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// game_sequencer: top-level game flow controller for the bouncing-ball game.
// Sequences ATTRACT -> PLAY <-> PAUSE -> OVER -> ATTRACT. Tracks lives and the
// bounce score, and issues ball restart, ball enable and gravity tick controls.
//
// Ports:
//   frame_clk   in   1   frame clock, all state advances on its rising edge
//   Reset       in   1   asynchronous, active-high reset
//   keycode     in   8   current keyboard keycode (0 = no key)
//   ball_y      in  11   current ball Y position
//   on_platform in   1   high while the ball touches a platform
//   ball_rst    out  1   one-frame pulse restarting the ball (held during Reset)
//   ball_en     out  1   high while in PLAY
//   grav_tick   out  1   one-frame pulse granting one gravity increment
//   state       out  2   00 ATTRACT, 01 PLAY, 10 PAUSE, 11 OVER
//   lives       out  2   remaining lives
//   score       out 16   bounce count for the current game (saturating)
module game_sequencer #(
    parameter logic [7:0]  START_KEY    = 8'd44,
    parameter logic [7:0]  PAUSE_KEY    = 8'd19,
    parameter int unsigned LIVES_INIT   = 3,
    parameter int unsigned GRAV_DIV     = 8,
    parameter logic [10:0] FLOOR_Y      = 11'd469,
    parameter logic [7:0]  OVER_TIMEOUT = 8'd255
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [7:0]  keycode,
    input  logic [10:0] ball_y,
    input  logic        on_platform,
    output logic        ball_rst,
    output logic        ball_en,
    output logic        grav_tick,
    output logic [1:0]  state,
    output logic [1:0]  lives,
    output logic [15:0] score
);

    localparam int unsigned GRAV_W = 4;
    localparam int unsigned HOLD_W = 2;
    localparam int unsigned OVER_W = 8;

    typedef enum logic [1:0] {
        ST_ATTRACT = 2'b00,
        ST_PLAY    = 2'b01,
        ST_PAUSE   = 2'b10,
        ST_OVER    = 2'b11
    } state_t;

    state_t              st;
    logic [7:0]          prev_key;
    logic                plat_q;
    logic [GRAV_W-1:0]   grav_cnt;
    logic [HOLD_W-1:0]   holdoff;
    logic [OVER_W-1:0]   over_cnt;

    logic start_press;
    logic pause_press;
    logic bounce;
    logic death;
    logic grav_wrap;
    logic over_done;

    assign state = st;

    // Frame-level event decode from the current inputs and registered history
    always_comb begin
        start_press = (keycode == START_KEY) && (prev_key != START_KEY);
        pause_press = (keycode == PAUSE_KEY) && (prev_key != PAUSE_KEY);
        bounce      = on_platform && !plat_q;
        death       = (ball_y >= FLOOR_Y) && (holdoff == '0);
        grav_wrap   = (grav_cnt == GRAV_W'(GRAV_DIV - 1));
        // OVER ends on the frame the counter would reach the timeout value
        over_done   = ({1'b0, over_cnt} + 9'd1) == {1'b0, OVER_TIMEOUT};
    end

    // Game flow state machine with registered outputs
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            st        <= ST_ATTRACT;
            prev_key  <= '0;
            plat_q    <= 1'b0;
            grav_cnt  <= '0;
            holdoff   <= '0;
            over_cnt  <= '0;
            lives     <= '0;
            score     <= '0;
            ball_rst  <= 1'b1;
            ball_en   <= 1'b0;
            grav_tick <= 1'b0;
        end else begin
            prev_key  <= keycode;
            plat_q    <= on_platform;
            ball_rst  <= 1'b0;
            grav_tick <= 1'b0;

            unique case (st)
                ST_ATTRACT: begin
                    if (start_press) begin
                        st       <= ST_PLAY;
                        lives    <= 2'(LIVES_INIT);
                        score    <= '0;
                        grav_cnt <= '0;
                        holdoff  <= '0;
                        ball_rst <= 1'b1;
                        ball_en  <= 1'b1;
                    end
                end

                ST_PLAY: begin
                    if (death && (lives <= 2'd1)) begin
                        // Last life lost: leave PLAY with counters frozen
                        st       <= ST_OVER;
                        lives    <= '0;
                        over_cnt <= '0;
                        ball_en  <= 1'b0;
                    end else if (pause_press && !death) begin
                        st      <= ST_PAUSE;
                        ball_en <= 1'b0;
                    end else begin
                        // Still in PLAY this frame: gravity phase advances
                        grav_tick <= grav_wrap;
                        grav_cnt  <= grav_wrap ? '0 : grav_cnt + GRAV_W'(1);
                        if (death) begin
                            lives    <= lives - 2'd1;
                            ball_rst <= 1'b1;
                            holdoff  <= HOLD_W'(3);
                        end else begin
                            if (holdoff != '0) begin
                                holdoff <= holdoff - HOLD_W'(1);
                            end
                            if (bounce && (score != 16'hFFFF)) begin
                                score <= score + 16'd1;
                            end
                        end
                    end
                end

                ST_PAUSE: begin
                    if (pause_press) begin
                        st      <= ST_PLAY;
                        ball_en <= 1'b1;
                    end
                end

                ST_OVER: begin
                    if (start_press || over_done) begin
                        st    <= ST_ATTRACT;
                        lives <= '0;
                        score <= '0;
                    end else begin
                        over_cnt <= over_cnt + OVER_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed and randomized bench for game_sequencer with an
// in-bench behavioural model of the game rules compared on every frame.
module tb_game_sequencer;

    logic        frame_clk = 1'b0;
    logic        Reset     = 1'b1;
    logic [7:0]  keycode   = 8'd0;
    logic [10:0] ball_y    = 11'd100;
    logic        on_platform = 1'b0;
    logic        ball_rst;
    logic        ball_en;
    logic        grav_tick;
    logic [1:0]  state;
    logic [1:0]  lives;
    logic [15:0] score;

    int total = 0;
    int bad   = 0;

    game_sequencer dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .keycode     (keycode),
        .ball_y      (ball_y),
        .on_platform (on_platform),
        .ball_rst    (ball_rst),
        .ball_en     (ball_en),
        .grav_tick   (grav_tick),
        .state       (state),
        .lives       (lives),
        .score       (score)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 attract, 1 play, 2 pause, 3 over
    int   m_mode = 0, m_lives = 0, m_score = 0, m_hold = 0;
    int   m_play_frames = 0, m_over_frames = 0;
    int   m_rst = 1, m_en = 0, m_tick = 0;
    int   m_prev_key = 0, m_prev_plat = 0;

    task automatic model_frame();
        bit start_p, pause_p, rise, dead;
        start_p = (int'(keycode) == 44) && (m_prev_key != 44);
        pause_p = (int'(keycode) == 19) && (m_prev_key != 19);
        rise    = on_platform && (m_prev_plat == 0);
        m_rst   = 0;
        m_tick  = 0;
        case (m_mode)
            0: if (start_p) begin
                m_mode = 1; m_lives = 3; m_score = 0; m_hold = 0;
                m_play_frames = 0; m_rst = 1;
            end
            1: begin
                dead = (int'(ball_y) >= 469) && (m_hold == 0);
                if (dead && m_lives == 1) begin
                    m_lives = 0; m_mode = 3; m_over_frames = 0;
                end else if (dead) begin
                    m_lives = m_lives - 1; m_rst = 1; m_hold = 3;
                end else if (pause_p) begin
                    m_mode = 2;
                end else begin
                    if (rise) m_score = (m_score >= 65535) ? 65535 : m_score + 1;
                    if (m_hold > 0) m_hold = m_hold - 1;
                end
                if (m_mode == 1) begin
                    m_play_frames++;
                    m_tick = ((m_play_frames % 8) == 0) ? 1 : 0;
                end
            end
            2: if (pause_p) m_mode = 1;
            default: begin
                m_over_frames++;
                if (start_p || m_over_frames == 255) begin
                    m_mode = 0; m_lives = 0; m_score = 0;
                end
            end
        endcase
        m_en        = (m_mode == 1) ? 1 : 0;
        m_prev_key  = int'(keycode);
        m_prev_plat = on_platform ? 1 : 0;
    endtask

    initial forever begin
        @(posedge frame_clk or posedge Reset);
        if (Reset) begin
            m_mode = 0; m_lives = 0; m_score = 0; m_hold = 0;
            m_play_frames = 0; m_over_frames = 0;
            m_rst = 1; m_en = 0; m_tick = 0; m_prev_key = 0; m_prev_plat = 0;
        end else begin
            model_frame();
        end
    end

    // Per-frame comparison of every output against the model
    initial forever begin
        @(negedge frame_clk);
        chk("m_state",     int'(state),     m_mode);
        chk("m_lives",     int'(lives),     m_lives);
        chk("m_score",     int'(score),     m_score);
        chk("m_ball_rst",  int'(ball_rst),  m_rst);
        chk("m_ball_en",   int'(ball_en),   m_en);
        chk("m_grav_tick", int'(grav_tick), m_tick);
    end

    task automatic frame(input logic [7:0] k, input logic [10:0] y, input logic p);
        #1;
        keycode     = k;
        ball_y      = y;
        on_platform = p;
        @(negedge frame_clk);
    endtask

    initial begin
        int n_rst, ticks, since, found;
        bit seen;
        logic [7:0] k;
        logic [10:0] y;
        logic p;

        repeat (2) @(negedge frame_clk);
        chk("rst_state", int'(state), 0);
        chk("rst_lives", int'(lives), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_ball_rst", int'(ball_rst), 1);
        chk("rst_ball_en", int'(ball_en), 0);
        #1 Reset = 1'b0;
        @(negedge frame_clk);
        chk("rst_release_ball_rst", int'(ball_rst), 0);

        // Start press, then held key must not retrigger
        frame(8'd44, 11'd100, 1'b0);
        chk("start_state", int'(state), 1);
        chk("start_lives", int'(lives), 3);
        chk("start_score", int'(score), 0);
        chk("start_ball_rst", int'(ball_rst), 1);
        n_rst = 0;
        for (int i = 0; i < 10; i++) begin
            frame(8'd44, 11'd100, 1'b0);
            n_rst += int'(ball_rst);
        end
        chk("held_start_no_rst", n_rst, 0);
        chk("held_start_state", int'(state), 1);

        // 24 PLAY frames: three ticks, eight frames apart
        ticks = 0; since = 0; seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            frame(8'd0, 11'd100, 1'b0);
            if (grav_tick) begin
                ticks++;
                if (seen) chk("tick_spacing", since + 1, 8);
                seen = 1'b1;
                since = 0;
            end else begin
                since++;
            end
        end
        chk("tick_count_24", ticks, 3);

        // Pause (with a bounce inside it), resume, gravity phase continues
        frame(8'd19, 11'd100, 1'b0);
        since += 1 - int'(grav_tick);
        chk("pause_state", int'(state), 2);
        chk("pause_ball_en", int'(ball_en), 0);
        for (int i = 0; i < 5; i++) begin
            frame(8'd0, 11'd100, (i == 1) ? 1'b1 : 1'b0);
            since += 1 - int'(grav_tick);
        end
        chk("pause_hold_state", int'(state), 2);
        chk("pause_no_score", int'(score), 0);
        frame(8'd19, 11'd100, 1'b0);
        since += 1 - int'(grav_tick);
        chk("resume_state", int'(state), 1);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            frame(8'd0, 11'd100, 1'b0);
            if (grav_tick) found = 1; else since++;
        end
        chk("resume_tick_seen", found, 1);
        chk("resume_tick_gap", since + 1, 15);

        // Four bounces in PLAY
        for (int i = 0; i < 4; i++) begin
            frame(8'd0, 11'd100, 1'b1);
            frame(8'd0, 11'd100, 1'b0);
        end
        chk("bounce_score", int'(score), 4);

        // Death with holdoff
        frame(8'd0, 11'd470, 1'b0);
        chk("death1_lives", int'(lives), 2);
        chk("death1_ball_rst", int'(ball_rst), 1);
        chk("death1_state", int'(state), 1);
        for (int i = 0; i < 3; i++) begin
            frame(8'd0, 11'd470, 1'b0);
            chk("holdoff_lives", int'(lives), 2);
        end
        frame(8'd0, 11'd470, 1'b0);
        chk("death2_lives", int'(lives), 1);
        chk("death2_ball_rst", int'(ball_rst), 1);
        for (int i = 0; i < 4; i++) frame(8'd0, 11'd100, 1'b0);

        // Last-life death beats pause; then OVER times out
        frame(8'd19, 11'd470, 1'b0);
        chk("over_state", int'(state), 3);
        chk("over_lives", int'(lives), 0);
        chk("over_ball_en", int'(ball_en), 0);
        for (int i = 0; i < 254; i++) frame(8'd0, 11'd100, 1'b0);
        chk("over_254_state", int'(state), 3);
        chk("over_254_score", int'(score), 4);
        frame(8'd0, 11'd100, 1'b0);
        chk("over_timeout_state", int'(state), 0);
        chk("over_timeout_score", int'(score), 0);

        // New game to lives=2, score=7, then asynchronous reset
        frame(8'd44, 11'd100, 1'b0);
        chk("restart_lives", int'(lives), 3);
        frame(8'd0, 11'd470, 1'b0);
        for (int i = 0; i < 7; i++) begin
            frame(8'd0, 11'd100, 1'b1);
            frame(8'd0, 11'd100, 1'b0);
        end
        chk("pre_reset_lives", int'(lives), 2);
        chk("pre_reset_score", int'(score), 7);
        #2 Reset = 1'b1;
        #1;
        chk("async_state", int'(state), 0);
        chk("async_lives", int'(lives), 0);
        chk("async_score", int'(score), 0);
        chk("async_ball_en", int'(ball_en), 0);
        chk("async_ball_rst", int'(ball_rst), 1);
        @(negedge frame_clk);
        #2 Reset = 1'b0;

        // Randomized play against the model
        k = 8'd0; p = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 6)       k = 8'd44;
            else if (r < 14) k = 8'd19;
            else if (r < 40) k = k;
            else if (r < 80) k = 8'd0;
            else             k = 8'($urandom_range(1, 255));
            if ($urandom_range(0, 11) == 0) y = 11'($urandom_range(465, 475));
            else                            y = 11'($urandom_range(0, 460));
            if ($urandom_range(0, 2) == 0) p = ~p;
            if ($urandom_range(0, 799) == 0) begin
                #2 Reset = 1'b1;
                @(negedge frame_clk);
                #2 Reset = 1'b0;
            end
            frame(k, y, p);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
